load_sequencer: RTL and testbench

LOAD_SEQUENCER -- requirements
Module: load_sequencer

---
 rtl/load_sequencer.sv | 259 +++++++++++++++++++++++++
 tb/tb_load_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_sequencer.sv
// -----------------------------------------------------------------------------
// load_sequencer
//
// Executes one load instruction (LW, LB, LBU, LH, LHU) at a time. It decodes
// the opcode, forms the effective address base + sext(imm), checks alignment,
// issues a word read to memory with a bounded wait for the acknowledge, extracts
// and extends the addressed lane, and writes the result to the register file.
//
// Sequence: IDLE -> DECODE -> ADDR -> MEM -> WB -> IDLE
//           DECODE/ADDR/MEM may divert to ERR -> IDLE
//
// Parameters
//   TIMEOUT      maximum MEM cycles spent waiting for mem_ack (2..255)
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   start        request to run `instruction`; only looked at in IDLE
//   instruction  opcode[31:26], rs[25:21], rt[20:16], imm[15:0]
//   base         value of register rs, captured together with instruction
//   busy         high in every state except IDLE
//   done         one-cycle pulse, coincident with the WB state
//   err          one-cycle pulse, coincident with the ERR state
//   mem_req      read request, high for the whole MEM state
//   mem_addr     word address {ea[31:2], 2'b00}; holds its value outside MEM
//   mem_ack      read data valid; ignored outside MEM
//   mem_rdata    read word, byte lane n = bits [8n+7:8n]
//   rf_we        register-file write enable, one cycle in WB (never for rt=0)
//   rf_waddr     destination register; holds last written value
//   rf_wdata     extended load result; holds last written value
//
// All outputs are registered. done/rf_we are visible during the WB cycle, so
// a register file clocked on the same edge commits the result on the edge that
// ends WB (start edge N, zero-wait ack -> commit at edge N+4).
// -----------------------------------------------------------------------------
module load_sequencer #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] instruction,
  input  logic [31:0] base,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LHU = 6'h25;

  // Value of the wait counter during the last permitted MEM cycle.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_ADDR   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    K_LW  = 3'd0,
    K_LB  = 3'd1,
    K_LBU = 3'd2,
    K_LH  = 3'd3,
    K_LHU = 3'd4
  } kind_t;

  state_t             state_q;
  kind_t              kind_q;
  logic [5:0]         op_q;
  logic [4:0]         rt_q;
  logic signed [15:0] imm_q;
  logic [31:0]        base_q;
  logic [1:0]         ea_lo_q;
  logic [7:0]         wait_q;

  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic               mem_req_q;
  logic [31:0]        mem_addr_q;
  logic               rf_we_q;
  logic [4:0]         rf_waddr_q;
  logic [31:0]        rf_wdata_q;

  // The rs index is already resolved into `base` by the caller, so the field
  // itself carries no information for this block.
  logic [4:0]         rs_unused;
  assign rs_unused = instruction[25:21];

  // Effective address, 32-bit wrap-around; no overflow detection.
  logic signed [31:0] imm_ext;
  logic [31:0]        ea_d;
  assign imm_ext = {{16{imm_q[15]}}, imm_q};
  assign ea_d    = base_q + imm_ext;

  function automatic logic is_legal(input logic [5:0] op);
    is_legal = (op == OP_LW) || (op == OP_LB) || (op == OP_LBU) ||
               (op == OP_LH) || (op == OP_LHU);
  endfunction

  function automatic kind_t to_kind(input logic [5:0] op);
    case (op)
      OP_LB:   to_kind = K_LB;
      OP_LBU:  to_kind = K_LBU;
      OP_LH:   to_kind = K_LH;
      OP_LHU:  to_kind = K_LHU;
      default: to_kind = K_LW;
    endcase
  endfunction

  // Words must be 4-byte aligned, halves 2-byte aligned, bytes never fault.
  function automatic logic misaligned(input kind_t k, input logic [1:0] lo);
    case (k)
      K_LW:        misaligned = (lo != 2'b00);
      K_LH, K_LHU: misaligned = lo[0];
      default:     misaligned = 1'b0;
    endcase
  endfunction

  // Select the addressed lane of the read word and extend it to 32 bits.
  function automatic logic [31:0] extract(input kind_t       k,
                                          input logic [1:0]  lo,
                                          input logic [31:0] w);
    logic [7:0]  b8;
    logic [15:0] h16;
    b8  = w[{lo, 3'b000} +: 8];
    h16 = w[{lo[1], 4'b0000} +: 16];
    case (k)
      K_LB:    extract = {{24{b8[7]}}, b8};
      K_LBU:   extract = {24'h000000, b8};
      K_LH:    extract = {{16{h16[15]}}, h16};
      K_LHU:   extract = {16'h0000, h16};
      default: extract = w;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      kind_q     <= K_LW;
      op_q       <= 6'd0;
      rt_q       <= 5'd0;
      imm_q      <= 16'sd0;
      base_q     <= 32'd0;
      ea_lo_q    <= 2'd0;
      wait_q     <= 8'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'd0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= 32'd0;
    end else begin
      // Pulse outputs are only ever raised for the single WB/ERR cycle.
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rf_we_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q    <= instruction[31:26];
            rt_q    <= instruction[20:16];
            imm_q   <= instruction[15:0];
            base_q  <= base;
            busy_q  <= 1'b1;
            state_q <= S_DECODE;
          end
        end

        S_DECODE: begin
          if (is_legal(op_q)) begin
            kind_q  <= to_kind(op_q);
            state_q <= S_ADDR;
          end else begin
            err_q   <= 1'b1;
            state_q <= S_ERR;
          end
        end

        S_ADDR: begin
          ea_lo_q <= ea_d[1:0];
          if (misaligned(kind_q, ea_d[1:0])) begin
            err_q   <= 1'b1;
            state_q <= S_ERR;
          end else begin
            mem_req_q  <= 1'b1;
            mem_addr_q <= {ea_d[31:2], 2'b00};
            wait_q     <= 8'd0;
            state_q    <= S_MEM;
          end
        end

        S_MEM: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            done_q    <= 1'b1;
            // r0 is hard-wired zero: complete the load but skip the write.
            if (rt_q != 5'd0) begin
              rf_we_q    <= 1'b1;
              rf_waddr_q <= rt_q;
              rf_wdata_q <= extract(kind_q, ea_lo_q, mem_rdata);
            end
            state_q <= S_WB;
          end else if (wait_q == WAIT_LAST) begin
            mem_req_q <= 1'b0;
            err_q     <= 1'b1;
            state_q   <= S_ERR;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end

        S_WB: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        S_ERR: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          busy_q    <= 1'b0;
          mem_req_q <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_load_sequencer.sv
// -----------------------------------------------------------------------------
// tb_load_sequencer
//
// Scoreboard bench. The stimulus side predicts the outcome of every load from
// the instruction-set rules (effective address, alignment, lane selection,
// extension, r0 suppression, cycle of completion) and queues it; a monitor
// process pops one prediction whenever done or err appears and compares.
// A memory responder answers mem_req after a programmable number of cycles
// and toggles mem_ack randomly whenever no request is outstanding.
//
// Cycle numbering: `cyc` counts rising edges. A start sampled at edge N
// shows done/rf_we in the cycle after edge N+3+wait, so the register file
// commits it at edge N+4+wait.
// -----------------------------------------------------------------------------
module tb_load_sequencer;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] instruction;
  logic [31:0] base;
  logic        busy, done, err, mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  load_sequencer #(.TIMEOUT(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .instruction(instruction),
    .base       (base),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- memory environment ----------------
  int          ack_delay = 0;
  bit          no_ack    = 1'b0;
  bit          fixed_en  = 1'b0;
  logic [31:0] fixed_word = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (fixed_en) return fixed_word;
    return (a * 32'h9E3779B1) ^ 32'hC3A55A3C;
  endfunction

  initial begin
    int k;
    k = 0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      mem_rdata = mem_word(mem_addr);
      if (mem_req) begin
        mem_ack = (!no_ack && k == ack_delay);
        k++;
      end else begin
        mem_ack = 1'($urandom_range(0, 1));
        k = 0;
      end
    end
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    bit          is_err;
    int          cyc;
    int          req;
    bit          we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] maddr;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_addr_last  = 32'h0;
  logic [4:0]  m_waddr_last = 5'h0;
  logic [31:0] m_wdata_last = 32'h0;

  task automatic predict(input logic [31:0] ins, input logic [31:0] b,
                         input int d, input bit na, input int n0);
    exp_t        e;
    int          size;
    bit          sgn;
    logic [31:0] ea, w, v;
    logic [4:0]  rt;
    rt = ins[20:16];
    e.is_err = 1'b0; e.req = 0; e.we = 1'b0; e.cyc = 0;
    case (ins[31:26])
      6'h23:   begin size = 4; sgn = 1'b0; end
      6'h20:   begin size = 1; sgn = 1'b1; end
      6'h24:   begin size = 1; sgn = 1'b0; end
      6'h21:   begin size = 2; sgn = 1'b1; end
      6'h25:   begin size = 2; sgn = 1'b0; end
      default: begin size = 0; sgn = 1'b0; end
    endcase
    if (size == 0) begin
      e.is_err = 1'b1; e.cyc = n0 + 1;
    end else begin
      ea = b + 32'($signed(ins[15:0]));
      if ((int'(ea[1:0]) % size) != 0) begin
        e.is_err = 1'b1; e.cyc = n0 + 2;
      end else begin
        m_addr_last = ea & 32'hFFFFFFFC;
        if (na) begin
          e.is_err = 1'b1; e.cyc = n0 + 2 + TMO; e.req = TMO;
        end else begin
          w = mem_word(m_addr_last);
          v = w >> (8 * int'(ea[1:0]));
          if (size == 1) begin
            v = v & 32'h000000FF;
            if (sgn && v[7]) v = v | 32'hFFFFFF00;
          end else if (size == 2) begin
            v = v & 32'h0000FFFF;
            if (sgn && v[15]) v = v | 32'hFFFF0000;
          end
          e.cyc = n0 + 3 + d;
          e.req = d + 1;
          if (rt != 5'd0) begin
            e.we = 1'b1;
            m_waddr_last = rt;
            m_wdata_last = v;
          end
        end
      end
    end
    e.waddr = m_waddr_last;
    e.wdata = m_wdata_last;
    e.maddr = m_addr_last;
    q.push_back(e);
  endtask

  int req_cycles = 0;
  bit chk_idle   = 1'b0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (chk_idle) begin
          check("busy_low_after_end", busy, 0);
          chk_idle = 1'b0;
        end
        if (mem_req) req_cycles++;
        check("rf_we_only_in_done", rf_we & ~done, 0);
        if (done || err) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_end: done=%b err=%b, expected no completion", done, err);
          end else begin
            e = q.pop_front();
            check("err_pulse", err, e.is_err);
            check("done_pulse", done, !e.is_err);
            check("end_cycle", cyc, e.cyc);
            check("mem_req_cycles", req_cycles, e.req);
            check("rf_we", rf_we, e.we);
            check("rf_waddr", rf_waddr, e.waddr);
            check("rf_wdata", rf_wdata, e.wdata);
            check("mem_addr", mem_addr, e.maddr);
          end
          req_cycles = 0;
          chk_idle   = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_load(input logic [31:0] ins, input logic [31:0] b,
                          input int d, input bit na, input bit junk);
    int n;
    @(negedge clk);
    n = 0;
    while (busy && n < 300) begin @(negedge clk); n++; end
    ack_delay   = d;
    no_ack      = na;
    instruction = ins;
    base        = b;
    start       = 1'b1;
    predict(ins, b, d, na, cyc + 1);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i > 0 && !busy) break;
      // Starts and operand changes while busy must have no effect.
      if (junk) begin
        start       = 1'($urandom_range(0, 1));
        instruction = $urandom;
        base        = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("load_completes", busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},     busy,     0);
    check({tag, "_done"},     done,     0);
    check({tag, "_err"},      err,      0);
    check({tag, "_mem_req"},  mem_req,  0);
    check({tag, "_rf_we"},    rf_we,    0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_rf_waddr"}, rf_waddr, 0);
    check({tag, "_rf_wdata"}, rf_wdata, 0);
  endtask

  task automatic reset_mid_mem();
    int n;
    @(negedge clk);
    ack_delay   = 0;
    no_ack      = 1'b1;
    instruction = 32'h8C0A0010;
    base        = 32'h00000100;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!mem_req && n < 20) begin @(negedge clk); n++; end
    check("reached_mem", mem_req, 1);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1 check_all_zero("async_reset");
    q.delete();
    m_addr_last  = 32'h0;
    m_waddr_last = 5'h0;
    m_wdata_last = 32'h0;
    req_cycles   = 0;
    chk_idle     = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    no_ack = 1'b0;
  endtask

  initial begin
    logic [5:0]  op;
    logic [31:0] ins, b;
    reset = 1'b1; start = 1'b0; instruction = 32'h0; base = 32'h0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    #2 reset = 1'b0;

    // Directed cases with a fixed memory word.
    fixed_en = 1'b1; fixed_word = 32'h12345678;
    run_load(32'h8C090000, 32'h4, 0, 1'b0, 1'b0);   // LW r9 <- 12345678
    run_load(32'h8C090001, 32'h4, 0, 1'b0, 1'b0);   // LW ea=5 misaligned
    fixed_word = 32'h87654321;
    run_load(32'h80090003, 32'h4, 0, 1'b0, 1'b0);   // LB  -> FFFFFF87
    run_load(32'h90090003, 32'h4, 0, 1'b0, 1'b0);   // LBU -> 00000087
    run_load(32'h94090002, 32'h4, 0, 1'b0, 1'b0);   // LHU -> 00008765
    run_load(32'h84090002, 32'h4, 1, 1'b0, 1'b0);   // LH  -> FFFF8765
    run_load(32'h84090001, 32'h0, 0, 1'b0, 1'b0);   // LH misaligned
    fixed_en = 1'b0;
    run_load(32'h8C09FFFC, 32'h8, 3, 1'b0, 1'b0);   // ea=4, three wait cycles
    run_load(32'h8C0B0000, 32'h40, 0, 1'b1, 1'b0);  // no ack -> timeout
    run_load(32'hFC090000, 32'h0, 0, 1'b0, 1'b0);   // illegal opcode
    run_load(32'h8C000000, 32'h4, 0, 1'b0, 1'b0);   // rt=0: done, no write
    run_load(32'h8C0C0008, 32'hFFFFFFFC, TMO - 1, 1'b0, 1'b1); // wrap, last-chance ack
    reset_mid_mem();
    run_load(32'h8C0D0020, 32'h200, 2, 1'b0, 1'b0); // first load after reset

    // Randomized loads.
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 5))
        0:       op = 6'h23;
        1:       op = 6'h20;
        2:       op = 6'h24;
        3:       op = 6'h21;
        4:       op = 6'h25;
        default: op = 6'($urandom);
      endcase
      ins = $urandom;
      ins[31:26] = op;
      if ($urandom_range(0, 2) != 0) ins[1:0] = 2'b00;
      b = $urandom;
      if ($urandom_range(0, 2) != 0) b[1:0] = 2'b00;
      run_load(ins, b, $urandom_range(0, TMO - 1), ($urandom_range(0, 11) == 0),
               1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
